// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM encoding and byte-layout constants,
// used by both the SPI master controller and the SPI target.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    localparam int unsigned CMD_WR_BIT    = 7;
    localparam int unsigned SPI_BYTE_BITS = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with single-cycle rise/fall
// pulses derived from the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1]: synchroniser stages, [2]: previous synchronised level
    logic [2:0] pipe_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pipe_q <= {3{RST_VAL}};
        end else begin
            pipe_q <= {pipe_q[1:0], d_i};
        end
    end

    assign sync_o = pipe_q[1];
    assign rise_o = pipe_q[1] & ~pipe_q[2];
    assign fall_o = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave_regs.sv
// Mode-0 SPI target with a DEPTH x WIDTH register file, all pins oversampled on pclk_i.
// Optional macro SPI_SLV_STATUS_EN: shifts {err, frame_cnt[6:0]} out on miso during the address byte.
module spi_slave_regs
    import spi_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = 8'h00
) (
    input  logic             pclk_i,
    input  logic             prstn_i,
    input  logic             sclk_i,
    input  logic             ssel_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o,
    output logic             wr_stb_o,
    output logic [WIDTH-2:0] wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             err_o,
    output logic [7:0]       frame_cnt_o
);

    localparam int unsigned AW = WIDTH - 1;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sclk_sync_unused, sclk_rise, sclk_fall;
    logic ssel_sync, ssel_rise, ssel_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_i (pclk_i),
        .rstn_i(prstn_i),
        .d_i   (sclk_i),
        .sync_o(sclk_sync_unused),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    // ssel idles high, so its synchroniser resets high to avoid a false fall
    spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk_i (pclk_i),
        .rstn_i(prstn_i),
        .d_i   (ssel_i),
        .sync_o(ssel_sync),
        .rise_o(ssel_rise),
        .fall_o(ssel_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk_i (pclk_i),
        .rstn_i(prstn_i),
        .d_i   (mosi_i),
        .sync_o(mosi_sync),
        .rise_o(mosi_rise_unused),
        .fall_o(mosi_fall_unused)
    );

    spi_state_e       state_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-2:0] shift_in_q;
    logic [WIDTH-1:0] shift_out_q;
    logic             cmd_q;
    logic [AW-1:0]    addr_q;
    logic             byte_done_q;
    logic             load_q;
    logic             wr_stb_q;
    logic [AW-1:0]    wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic             err_q;
    logic [7:0]       frame_cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

`ifdef SPI_SLV_STATUS_EN
    logic [SPI_BYTE_BITS-1:0] status_q;
`endif

    logic [WIDTH-1:0] byte_in;
    logic             byte_last;
    logic             addr_ok;
    logic [AW-1:0]    addr_inc;
    logic             mem_we;

    assign byte_in   = {shift_in_q, mosi_sync};
    assign byte_last = (bit_cnt_q == CW'(WIDTH - 1));
    assign addr_ok   = (32'(addr_q) < DEPTH);
    assign addr_inc  = AW'((32'(addr_q) + 32'd1) % DEPTH);
    assign mem_we    = (state_q == ST_DATA) && sclk_rise && !ssel_rise
                       && byte_last && cmd_q && addr_ok;

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (mem_we) begin
            mem_q[addr_q[IW-1:0]] <= byte_in;
        end
    end

    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            cmd_q       <= 1'b0;
            addr_q      <= '0;
            byte_done_q <= 1'b0;
            load_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
`ifdef SPI_SLV_STATUS_EN
            status_q    <= '0;
`endif
        end else begin
            wr_stb_q <= 1'b0;
            // ssel rise ends the frame and masks any sclk edge in the same cycle
            if (ssel_rise) begin
                state_q <= ST_IDLE;
                load_q  <= 1'b0;
                if (state_q != ST_IDLE && bit_cnt_q != '0) begin
                    err_q <= 1'b1;
                end
                if (state_q == ST_DATA && byte_done_q) begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ssel_fall) begin
                            state_q     <= ST_ADDR;
                            bit_cnt_q   <= '0;
                            byte_done_q <= 1'b0;
                            load_q      <= 1'b0;
                            shift_out_q <= '0;
`ifdef SPI_SLV_STATUS_EN
                            status_q    <= {err_q, frame_cnt_q[6:0]};
`endif
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            shift_in_q <= byte_in[WIDTH-2:0];
                            bit_cnt_q  <= bit_cnt_q + CW'(1);
                            if (byte_last) begin
                                bit_cnt_q <= '0;
                                cmd_q     <= byte_in[CMD_WR_BIT];
                                addr_q    <= byte_in[AW-1:0];
                                load_q    <= 1'b1;
                                state_q   <= ST_DATA;
                            end
                        end
`ifdef SPI_SLV_STATUS_EN
                        if (sclk_fall) begin
                            status_q <= {status_q[SPI_BYTE_BITS-2:0], 1'b0};
                        end
`endif
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            shift_in_q <= byte_in[WIDTH-2:0];
                            bit_cnt_q  <= bit_cnt_q + CW'(1);
                            if (byte_last) begin
                                bit_cnt_q   <= '0;
                                byte_done_q <= 1'b1;
                                addr_q      <= addr_inc;
                                load_q      <= 1'b1;
                                if (cmd_q) begin
                                    if (addr_ok) begin
                                        wr_stb_q  <= 1'b1;
                                        wr_addr_q <= addr_q;
                                        wr_data_q <= byte_in;
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                            end
                        end else if (sclk_fall) begin
                            // first fall of each byte reloads from the current address
                            if (load_q) begin
                                load_q      <= 1'b0;
                                shift_out_q <= addr_ok ? mem_q[addr_q[IW-1:0]] : '0;
                                if (!addr_ok && !cmd_q) begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                shift_out_q <= {shift_out_q[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        miso_o = 1'b0;
        if (state_q == ST_DATA && !cmd_q) begin
            miso_o = shift_out_q[WIDTH-1];
        end
`ifdef SPI_SLV_STATUS_EN
        if (state_q == ST_ADDR) begin
            miso_o = status_q[SPI_BYTE_BITS-1];
        end
`endif
    end

    assign miso_oe_o   = ~ssel_sync;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign err_o       = err_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: table of complete frames plus hand-written
// reset-mid-frame, glitch and abort sequences.
module tb_spi_slave_regs;

    logic       pclk = 1'b0;
    logic       prstn;
    logic       sclk;
    logic       ssel;
    logic       mosi;
    logic       miso_o;
    logic       miso_oe_o;
    logic       wr_stb_o;
    logic [6:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       err_o;
    logic [7:0] frame_cnt_o;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         stb_cnt = 0;
    logic [6:0] last_waddr = '0;
    logic [7:0] last_wdata = '0;

    spi_slave_regs #(.WIDTH(8), .DEPTH(16), .RST_VAL(8'h00)) dut (
        .pclk_i     (pclk),
        .prstn_i    (prstn),
        .sclk_i     (sclk),
        .ssel_i     (ssel),
        .mosi_i     (mosi),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .wr_stb_o   (wr_stb_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .err_o      (err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (wr_stb_o === 1'b1) begin
            stb_cnt    = stb_cnt + 1;
            last_waddr = wr_addr_o;
            last_wdata = wr_data_o;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          pre;      // 0 none, 1 reset mid-frame first, 2 ssel glitch first
        logic [7:0]  a;
        int          nd;
        logic [31:0] d;
        bit          chk_rx;
        logic [31:0] exp_rx;
        int          exp_stb;
        logic [6:0]  exp_waddr;
        logic [7:0]  exp_wdata;
        logic        exp_err;
        logic [7:0]  exp_fc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = v[7-i];
            wait_clk(4);
            rx[7-i] = miso_o;
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] a, input int nd, input logic [31:0] d,
                         output logic [31:0] rx);
        logic [7:0] b;
        rx = '0;
        ssel = 1'b0;
        wait_clk(4);
        chk("oe_active", {31'd0, miso_oe_o}, 32'd1);
        send_bits(a, 8, b);
        for (int k = 0; k < nd; k++) begin
            send_bits(d[8*(nd-1-k) +: 8], 8, b);
            rx = (rx << 8) | {24'd0, b};
        end
        wait_clk(4);
        ssel = 1'b1;
        wait_clk(8);
        chk("oe_idle", {31'd0, miso_oe_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"},  {31'd0, miso_o},     32'd0);
        chk({tag, "_oe"},    {31'd0, miso_oe_o},  32'd0);
        chk({tag, "_stb"},   {31'd0, wr_stb_o},   32'd0);
        chk({tag, "_waddr"}, {25'd0, wr_addr_o},  32'd0);
        chk({tag, "_wdata"}, {24'd0, wr_data_o},  32'd0);
        chk({tag, "_err"},   {31'd0, err_o},      32'd0);
        chk({tag, "_fc"},    {24'd0, frame_cnt_o}, 32'd0);
    endtask

    task automatic reset_mid_frame();
        logic [7:0] b;
        ssel = 1'b0;
        wait_clk(4);
        send_bits(8'h81, 8, b);
        send_bits(8'hC0, 3, b);
        prstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wait_clk(2);
        ssel = 1'b1;
        sclk = 1'b0;
        wait_clk(2);
        prstn = 1'b1;
        wait_clk(4);
        $display("reset asserted mid-frame, outputs err=%b fc=%0d", err_o, frame_cnt_o);
    endtask

    task automatic glitch();
        ssel = 1'b0;
        wait_clk(4);
        ssel = 1'b1;
        wait_clk(8);
        chk("glitch_err", {31'd0, err_o}, 32'd0);
        chk("glitch_fc", {24'd0, frame_cnt_o}, 32'd3);
        $display("ssel glitch, err=%b fc=%0d", err_o, frame_cnt_o);
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  b;
        int          stb0;

        //          pre  a      nd d             rx  exp_rx         stb waddr  wdata  err   fc
        tbl[0] = '{0, 8'h83, 1, 32'h0000_00A5, 0, 32'h0,          1, 7'd3,  8'hA5, 1'b0, 8'd1};
        tbl[1] = '{0, 8'h03, 1, 32'h0000_0000, 1, 32'h0000_00A5,  0, 7'd0,  8'h00, 1'b0, 8'd2};
        tbl[2] = '{0, 8'h8E, 3, 32'h0011_2233, 0, 32'h0,          3, 7'd0,  8'h33, 1'b0, 8'd3};
        tbl[3] = '{0, 8'h0E, 3, 32'h0000_0000, 1, 32'h0011_2233,  0, 7'd0,  8'h00, 1'b0, 8'd4};
        tbl[4] = '{0, 8'h95, 1, 32'h0000_00FF, 0, 32'h0,          0, 7'd0,  8'h00, 1'b1, 8'd5};
        tbl[5] = '{0, 8'h15, 1, 32'h0000_0000, 1, 32'h0000_0000,  0, 7'd0,  8'h00, 1'b1, 8'd6};
        tbl[6] = '{1, 8'h81, 1, 32'h0000_005A, 0, 32'h0,          1, 7'd1,  8'h5A, 1'b0, 8'd1};
        tbl[7] = '{0, 8'h03, 1, 32'h0000_0000, 1, 32'h0000_0000,  0, 7'd0,  8'h00, 1'b0, 8'd2};
        tbl[8] = '{0, 8'h01, 1, 32'h0000_0000, 1, 32'h0000_005A,  0, 7'd0,  8'h00, 1'b0, 8'd3};
        tbl[9] = '{2, 8'h82, 1, 32'h0000_0077, 0, 32'h0,          1, 7'd2,  8'h77, 1'b0, 8'd4};

        prstn = 1'b0;
        sclk  = 1'b0;
        ssel  = 1'b1;
        mosi  = 1'b0;
        wait_clk(3);
        check_reset_outputs("rst");
        prstn = 1'b1;
        wait_clk(4);
        check_reset_outputs("post_rst");

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].pre == 1) reset_mid_frame();
            if (tbl[i].pre == 2) glitch();
            stb0 = stb_cnt;
            frame(tbl[i].a, tbl[i].nd, tbl[i].d, rx);
            if (tbl[i].chk_rx) chk($sformatf("v%0d_rx", i), rx, tbl[i].exp_rx);
            chk($sformatf("v%0d_stb", i), stb_cnt - stb0, tbl[i].exp_stb);
            if (tbl[i].exp_stb > 0) begin
                chk($sformatf("v%0d_waddr", i), {25'd0, last_waddr}, {25'd0, tbl[i].exp_waddr});
                chk($sformatf("v%0d_wdata", i), {24'd0, last_wdata}, {24'd0, tbl[i].exp_wdata});
            end
            chk($sformatf("v%0d_err", i), {31'd0, err_o}, {31'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_fc", i), {24'd0, frame_cnt_o}, {24'd0, tbl[i].exp_fc});
            $display("vec %0d addr_byte=%h rx=%h stb=%0d err=%b fc=%0d",
                     i, tbl[i].a, rx, stb_cnt - stb0, err_o, frame_cnt_o);
        end

        // aborted write: full address byte, then only 4 data bits
        stb0 = stb_cnt;
        ssel = 1'b0;
        wait_clk(4);
        send_bits(8'h82, 8, b);
        send_bits(8'hF0, 4, b);
        wait_clk(4);
        ssel = 1'b1;
        wait_clk(8);
        chk("abort_stb", stb_cnt - stb0, 32'd0);
        chk("abort_err", {31'd0, err_o}, 32'd1);
        chk("abort_fc", {24'd0, frame_cnt_o}, 32'd4);
        $display("abort frame, stb=%0d err=%b fc=%0d", stb_cnt - stb0, err_o, frame_cnt_o);

        frame(8'h02, 1, 32'h0, rx);
        chk("abort_readback", rx, 32'h0000_0077);
        chk("abort_readback_fc", {24'd0, frame_cnt_o}, 32'd5);
        $display("read addr 2 after abort, rx=%h fc=%0d", rx, frame_cnt_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
